iter_divider: RTL and testbench

//  Iterative radix-2 restoring divider serving RV32M DIV/DIVU/REM/REMU for the execute-stage ALU.
//  The ALU is the initiator: it issues one request and holds the pipeline (alu_stall) until this

---
 rtl/iter_divider.sv | 171 +++++++++++++++++
 tb/tb_iter_divider.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; sign fix-up and RISC-V special cases are handled internally.
module iter_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] ONE      = XLEN'(1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] x);
        return (~x) + ONE;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rem_op_q, rem_op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_s;

    logic            signed_op_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0] abs_a_s, abs_b_s;
    logic            div_zero_s, overflow_s;
    logic [XLEN:0]   shifted_s;
    logic [XLEN+1:0] trial_s;
    logic [XLEN-1:0] rem_next_s, quo_next_s, final_s;

    // Operand preparation and one restoring-division step.
    always_comb begin
        signed_op_s = ~op_i[0];
        a_neg_s     = signed_op_s & dividend_i[XLEN-1];
        b_neg_s     = signed_op_s & divisor_i[XLEN-1];
        abs_a_s     = a_neg_s ? twos_neg(dividend_i) : dividend_i;
        abs_b_s     = b_neg_s ? twos_neg(divisor_i) : divisor_i;
        div_zero_s  = (divisor_i == '0);
        overflow_s  = signed_op_s & (dividend_i == MIN_NEG) & (divisor_i == ALL_ONES);

        // The shifted remainder can need one bit more than XLEN; the extra top bit of trial is its sign.
        shifted_s = {rem_q, quo_q[XLEN-1]};
        trial_s   = {1'b0, shifted_s} - {2'b00, dvs_q};
        if (!trial_s[XLEN+1]) begin
            rem_next_s = trial_s[XLEN-1:0];
            quo_next_s = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_next_s = shifted_s[XLEN-1:0];
            quo_next_s = {quo_q[XLEN-2:0], 1'b0};
        end

        if (rem_op_q) begin
            final_s = neg_q ? twos_neg(rem_next_s) : rem_next_s;
        end else begin
            final_s = neg_q ? twos_neg(quo_next_s) : quo_next_s;
        end
    end

    // Next-state and datapath update; quo_q holds the signed final result while in DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_op_d = rem_op_q;
        neg_d    = neg_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        valid_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    rem_op_d = op_i[1];
                    neg_d    = op_i[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
                    rem_d    = '0;
                    cnt_d    = CNT_MAX;
                    dvs_d    = abs_b_s;
                    if (div_zero_s) begin
                        quo_d   = op_i[1] ? dividend_i : ALL_ONES;
                        state_d = DONE;
                    end else if (overflow_s) begin
                        quo_d   = op_i[1] ? '0 : MIN_NEG;
                        state_d = DONE;
                    end else begin
                        quo_d   = abs_a_s;
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_next_s;
                    if (cnt_q == '0) begin
                        quo_d   = final_s;
                        state_d = DONE;
                    end else begin
                        quo_d = quo_next_s;
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush_i) begin
                    valid_s  = 1'b1;
                    result_d = quo_q;
                end else begin
                    valid_s = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_op_q <= 1'b0;
            neg_q    <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_op_q <= rem_op_d;
            neg_q    <= neg_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
        end
    end

    // A flush landing in DONE must suppress the pulse and expose the previously committed result.
    assign busy_o   = (state_q != IDLE);
    assign valid_o  = valid_s;
    assign result_o = valid_s ? quo_q : result_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider (XLEN=32).
module tb_iter_divider;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] dividend_i = 32'd0;
    logic [31:0] divisor_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int checks = 0;
    int failures = 0;

    iter_divider #(.XLEN(32)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .result_o   (result_o)
    );

    always #5 clk_i = ~clk_i;

    // Issue one request and wait (bounded) for valid_o; lat is the cycle index of valid_o.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic pre_busy,
                         output int busy_err, output logic post_busy);
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b;
        pre_busy = busy_o;
        @(posedge clk_i); #1;
        start_i = 1'b0; dividend_i = ~a; divisor_i = b ^ 32'h5A5A_0F0F; op_i = ~op;
        lat = 1; busy_err = 0;
        while (!valid_o && lat < 40) begin
            if (!busy_o) busy_err++;
            @(posedge clk_i); #1;
            lat++;
        end
        if (!busy_o) busy_err++;
        res = result_o;
        @(posedge clk_i); #1;
        post_busy = busy_o;
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", busy_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset valid got=%b exp=0", valid_o); end
        checks++; if (result_o !== 32'h0) begin failures++; $display("FAIL reset result got=%h exp=00000000", result_o); end
        @(negedge clk_i); rst_ni = 1'b1;
    endtask

    task automatic run_table(input string name, input vec_t v [], input int n);
        int lat, berr; logic [31:0] res; logic pre, post;
        for (int i = 0; i < n; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, lat, res, pre, berr, post);
            checks++; if (res !== v[i].exp) begin failures++; $display("FAIL %s[%0d] result got=%h exp=%h", name, i, res, v[i].exp); end
            checks++; if (lat !== v[i].lat) begin failures++; $display("FAIL %s[%0d] latency got=%0d exp=%0d", name, i, lat, v[i].lat); end
            checks++; if (berr !== 0 || pre !== 1'b0 || post !== 1'b0) begin failures++; $display("FAIL %s[%0d] busy errs=%0d pre=%b post=%b exp 0/0/0", name, i, berr, pre, post); end
        end
    endtask

    task automatic test_unsigned();
        vec_t v [];
        v = new[6];
        v[0] = '{2'd1, 32'd100, 32'd7, 32'd14, 33};
        v[1] = '{2'd3, 32'd100, 32'd7, 32'd2, 33};
        v[2] = '{2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33};
        v[3] = '{2'd3, 32'd3, 32'd10, 32'd3, 33};
        v[4] = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33};
        v[5] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        run_table("unsigned", v, 6);
    endtask

    task automatic test_signed();
        vec_t v [];
        v = new[7];
        v[0] = '{2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
        v[1] = '{2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
        v[2] = '{2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        v[3] = '{2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 33};
        v[4] = '{2'd0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33};
        v[5] = '{2'd2, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33};
        v[6] = '{2'd0, 32'h8000_0000, 32'd1, 32'h8000_0000, 33};
        run_table("signed", v, 7);
    endtask

    task automatic test_special();
        vec_t v [];
        v = new[6];
        v[0] = '{2'd1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1};
        v[1] = '{2'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 1};
        v[2] = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        v[3] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        v[4] = '{2'd0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1};
        v[5] = '{2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1};
        run_table("special", v, 6);
    endtask

    // start_i at cycle 5 (CALC) and cycle 33 (DONE) must not create extra results.
    task automatic test_ignore_start();
        int valids = 0; int cyc; logic [31:0] res33 = 32'h0;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'd1; dividend_i = 32'd100; divisor_i = 32'd7;
        @(posedge clk_i); #1; start_i = 1'b0;
        for (cyc = 1; cyc <= 70; cyc++) begin
            if (cyc == 5)  begin start_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5; end
            if (cyc == 33) begin start_i = 1'b1; dividend_i = 32'd60; divisor_i = 32'd6; end
            if (valid_o) begin valids++; if (cyc == 33) res33 = result_o; end
            @(posedge clk_i); #1;
            start_i = 1'b0;
        end
        checks++; if (valids !== 1) begin failures++; $display("FAIL ignore_start valid count got=%0d exp=1", valids); end
        checks++; if (res33 !== 32'd14) begin failures++; $display("FAIL ignore_start result@33 got=%h exp=0000000e", res33); end
        checks++; if (result_o !== 32'd14 || busy_o !== 1'b0) begin failures++; $display("FAIL ignore_start final result=%h busy=%b exp 0000000e/0", result_o, busy_o); end
    endtask

    task automatic test_flush();
        int valids = 0; int lat, berr; logic [31:0] res; logic pre, post;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'd1; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd1;
        @(posedge clk_i); #1; start_i = 1'b0;
        wait_cycles(9);
        flush_i = 1'b1;
        @(posedge clk_i); #1; flush_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin failures++; $display("FAIL flush_calc state busy=%b valid=%b exp 0/0", busy_o, valid_o); end
        checks++; if (result_o !== 32'd14) begin failures++; $display("FAIL flush_calc result got=%h exp=0000000e", result_o); end
        for (int k = 0; k < 40; k++) begin
            if (valid_o) valids++;
            @(posedge clk_i); #1;
        end
        checks++; if (valids !== 0) begin failures++; $display("FAIL flush_calc late valid count got=%0d exp=0", valids); end
        do_op(2'd1, 32'hFFFF_FFFF, 32'd1, lat, res, pre, berr, post);
        checks++; if (res !== 32'hFFFF_FFFF || lat !== 33) begin failures++; $display("FAIL flush_restart result=%h lat=%0d exp ffffffff/33", res, lat); end
    endtask

    // Flush landing on the DONE cycle suppresses valid_o and keeps the old result.
    task automatic test_flush_done();
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'd1; dividend_i = 32'd60; divisor_i = 32'd6;
        @(posedge clk_i); #1; start_i = 1'b0;
        wait_cycles(32);
        checks++; if (valid_o !== 1'b1 || result_o !== 32'd10) begin failures++; $display("FAIL flush_done pre valid=%b result=%h exp 1/0000000a", valid_o, result_o); end
        flush_i = 1'b1; #1;
        checks++; if (valid_o !== 1'b0 || result_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL flush_done during valid=%b result=%h exp 0/ffffffff", valid_o, result_o); end
        @(posedge clk_i); #1; flush_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || result_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL flush_done after busy=%b result=%h exp 0/ffffffff", busy_o, result_o); end
    endtask

    task automatic test_flush_start_idle();
        int hits = 0;
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'd1; dividend_i = 32'd9; divisor_i = 32'd0;
        @(posedge clk_i); #1; start_i = 1'b0; flush_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy_o || valid_o) hits++;
            @(posedge clk_i); #1;
        end
        checks++; if (hits !== 0 || result_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL flush_start_idle activity=%0d result=%h exp 0/ffffffff", hits, result_o); end
    endtask

    task automatic test_reset_midop();
        int lat, berr; logic [31:0] res; logic pre, post;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'd1; dividend_i = 32'd100; divisor_i = 32'd7;
        @(posedge clk_i); #1; start_i = 1'b0;
        wait_cycles(9);
        rst_ni = 1'b0; #1;
        checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'h0) begin failures++; $display("FAIL reset_midop busy=%b valid=%b result=%h exp 0/0/00000000", busy_o, valid_o, result_o); end
        @(negedge clk_i); rst_ni = 1'b1;
        do_op(2'd0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, res, pre, berr, post);
        checks++; if (res !== 32'd14 || lat !== 33) begin failures++; $display("FAIL reset_recover result=%h lat=%0d exp 0000000e/33", res, lat); end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0:    return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b)));
            2'd1:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            2'd2:    return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic test_random();
        int lat, berr; logic [31:0] res, a, b, exp; logic pre, post; logic [1:0] op;
        for (int i = 0; i < 16; i++) begin
            op = 2'(i % 4);
            a  = (i % 5 == 0) ? 32'd0 : $urandom;
            case (i % 4)
                0:       b = 32'd1;
                1:       b = $urandom;
                2:       b = {16'h0000, 16'($urandom)};
                default: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
            endcase
            if (b == 32'd0) b = 32'd3;
            exp = ref_model(op, a, b);
            do_op(op, a, b, lat, res, pre, berr, post);
            checks++; if (res !== exp) begin failures++; $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, res, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_ignore_start();
        test_flush();
        test_flush_done();
        test_flush_start_idle();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
